// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master issuing ID/address/data register frames
module spi_master #(
    parameter int          CLK_DIV   = 4,
    parameter int          SS_SETUP  = 4,
    parameter int          SS_GAP    = 8,
    parameter logic [7:0]  SLAVE_IDW = 8'hFF,
    parameter logic [7:0]  SLAVE_IDR = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  bc, bc_n;
    logic [23:0] shreg, shreg_n;
    logic [7:0]  rx, rx_n;
    logic [7:0]  rdata_n;
    logic        op_rw, op_rw_n;
    logic        ss_n, sclk_n, mosi_n, busy_n, done_n;

    // A reset that lands mid-frame leaves the last read result intact;
    // a reset held for two or more cycles always clears rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            bc    <= '0;
            shreg <= '0;
            rx    <= '0;
            op_rw <= 1'b0;
            ss    <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            if (!busy)
                rdata <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bc    <= bc_n;
            shreg <= shreg_n;
            rx    <= rx_n;
            op_rw <= op_rw_n;
            ss    <= ss_n;
            sclk  <= sclk_n;
            mosi  <= mosi_n;
            busy  <= busy_n;
            done  <= done_n;
            rdata <= rdata_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bc_n    = bc;
        shreg_n = shreg;
        rx_n    = rx;
        op_rw_n = op_rw;
        ss_n    = ss;
        sclk_n  = sclk;
        mosi_n  = mosi;
        busy_n  = busy;
        done_n  = 1'b0;
        rdata_n = rdata;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_n = {rw ? SLAVE_IDW : SLAVE_IDR, addr, rw ? wdata : 8'h00};
                    op_rw_n = rw;
                    mosi_n  = rw ? SLAVE_IDW[7] : SLAVE_IDR[7];
                    ss_n    = 1'b0;
                    sclk_n  = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    bc_n    = '0;
                    rx_n    = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                sclk_n = 1'b0;
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                        // miso is sampled in the cycle before the rising edge is driven
                        if (bc >= 5'd16 && !op_rw)
                            rx_n = {rx[6:0], miso};
                    end else begin
                        sclk_n = 1'b0;
                        if (bc < 5'd23) begin
                            shreg_n = {shreg[22:0], 1'b0};
                            mosi_n  = shreg[22];
                            bc_n    = bc + 5'd1;
                        end else begin
                            mosi_n  = 1'b0;
                            state_n = HOLD;
                        end
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            HOLD: begin
                sclk_n = 1'b0;
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    ss_n    = 1'b1;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    if (!op_rw)
                        rdata_n = rx;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master with a register-file slave model
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2, rw;
    logic [7:0] addr, wdata;
    logic       busy1, done1, ss1, sclk1, mosi1, miso1;
    logic       busy2, done2, ss2, sclk2, mosi2, miso2;
    logic [7:0] rdata1, rdata2;

    int errors = 0;
    int checks = 0;

    spi_master #(.CLK_DIV(4)) dut1 (
        .clock(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
    );

    spi_master #(.CLK_DIV(16)) dut2 (
        .clock(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy2), .done(done2), .rdata(rdata2), .ss(ss2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
    );

    initial forever #5 clk = ~clk;

    // Slave model: shared register file, one frame decoder per master
    logic [7:0]  mem [256];
    int          rises [2];
    logic [23:0] sr [2];
    logic [23:0] last_frame [2];
    int          last_rises [2];
    logic [7:0]  cap_addr [2];
    logic        prev_ss [2];
    logic        prev_sclk [2];
    int          run [2];
    int          last_high [2];

    always @(posedge clk) begin
        logic [1:0] sck, ssv, mo;
        sck = {sclk2, sclk1};
        ssv = {ss2, ss1};
        mo  = {mosi2, mosi1};
        for (int i = 0; i < 2; i++) begin
            if (prev_ss[i] && !ssv[i]) begin
                rises[i] <= 0;
                sr[i]    <= '0;
            end else if (!ssv[i] && !prev_sclk[i] && sck[i]) begin
                sr[i]    <= {sr[i][22:0], mo[i]};
                rises[i] <= rises[i] + 1;
                if (rises[i] == 15)
                    cap_addr[i] <= {sr[i][6:0], mo[i]};
            end
            if (!prev_ss[i] && ssv[i]) begin
                last_frame[i] <= sr[i];
                last_rises[i] <= rises[i];
                if (rises[i] == 24 && sr[i][23:16] == 8'hFF)
                    mem[sr[i][15:8]] <= sr[i][7:0];
            end
            prev_ss[i]   <= ssv[i];
            prev_sclk[i] <= sck[i];
        end
    end

    always @(negedge clk) begin
        logic [7:0] v0, v1;
        v0 = mem[cap_addr[0]];
        v1 = mem[cap_addr[1]];
        miso1 <= (rises[0] >= 16 && rises[0] < 24) ? v0[23 - rises[0]] : 1'b0;
        miso2 <= (rises[1] >= 16 && rises[1] < 24) ? v1[23 - rises[1]] : 1'b0;
        if (sclk1) run[0] <= run[0] + 1;
        else if (run[0] > 0) begin last_high[0] <= run[0]; run[0] <= 0; end
        if (sclk2) run[1] <= run[1] + 1;
        else if (run[1] > 0) begin last_high[1] <= run[1]; run[1] <= 0; end
    end

    // Issues one frame and returns start-to-done latency (-1 on timeout)
    task automatic do_frame(input int which, input logic r, input logic [7:0] a, input logic [7:0] d,
                            input bit no_wait, input int pulse_a, input int pulse_b,
                            output int lat, output int gap_cnt, output logic ss_after);
        if (!no_wait) @(negedge clk);
        rw = r; addr = a; wdata = d;
        if (which == 0) start1 = 1'b1; else start2 = 1'b1;
        lat = 0;
        gap_cnt = 0;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        lat = 1;
        ss_after = (which == 0) ? ss1 : ss2;
        while (!((which == 0) ? done1 : done2) && lat < 3000) begin
            if ((which == 0) ? (ss1 && busy1) : (ss2 && busy2)) gap_cnt++;
            if (lat == pulse_a || lat == pulse_b) begin
                start1 = 1'b1; rw = 1'b0; addr = 8'h77;
            end else begin
                start1 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start1 = 1'b0;
        if (lat >= 3000) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ss1, sclk1, mosi1, busy1, done1} !== 5'b10000) begin
            errors++; $display("FAIL reset_pins: got ss/sclk/mosi/busy/done=%b want 10000", {ss1, sclk1, mosi1, busy1, done1});
        end
        checks++;
        if (rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata1); end
        reset = 1'b0;
    endtask

    task automatic test_write;
        int lat, g; logic s;
        do_frame(0, 1'b1, 8'h10, 8'hA5, 1'b0, 0, 0, lat, g, s);
        @(negedge clk);
        checks++;
        if (lat !== 209) begin errors++; $display("FAIL write_latency: got %0d want 209", lat); end
        checks++;
        if (last_frame[0] !== 24'hFF10A5) begin errors++; $display("FAIL write_frame: got %h want FF10A5", last_frame[0]); end
        checks++;
        if (last_rises[0] !== 24) begin errors++; $display("FAIL write_rises: got %0d want 24", last_rises[0]); end
        checks++;
        if (mem[8'h10] !== 8'hA5) begin errors++; $display("FAIL write_reg: got %h want A5", mem[8'h10]); end
        checks++;
        if (rdata1 !== 8'h00) begin errors++; $display("FAIL write_rdata_held: got %h want 00", rdata1); end
    endtask

    task automatic test_read;
        int lat, g; logic s;
        do_frame(0, 1'b0, 8'h10, 8'h5F, 1'b0, 0, 0, lat, g, s);
        checks++;
        if (rdata1 !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h want A5", rdata1); end
        checks++;
        if (lat !== 209) begin errors++; $display("FAIL read_latency: got %0d want 209", lat); end
        repeat (20) @(negedge clk);
        checks++;
        if (last_frame[0] !== 24'h001000) begin errors++; $display("FAIL read_frame: got %h want 001000", last_frame[0]); end
        checks++;
        if (rdata1 !== 8'hA5) begin errors++; $display("FAIL read_rdata_hold: got %h want A5", rdata1); end
    endtask

    task automatic test_ignore_start;
        int lat, g; logic s;
        do_frame(0, 1'b1, 8'h13, 8'h3C, 1'b0, 10, 100, lat, g, s);
        @(negedge clk);
        checks++;
        if (lat !== 209) begin errors++; $display("FAIL ignore_latency: got %0d want 209", lat); end
        checks++;
        if (last_frame[0] !== 24'hFF133C) begin errors++; $display("FAIL ignore_frame: got %h want FF133C", last_frame[0]); end
        checks++;
        if (mem[8'h13] !== 8'h3C) begin errors++; $display("FAIL ignore_reg: got %h want 3C", mem[8'h13]); end
        repeat (300) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy=%b want 0", busy1); end
    endtask

    task automatic test_reset_abort;
        int n, lat, g; logic s; bit saw_done;
        @(negedge clk);
        rw = 1'b1; addr = 8'h30; wdata = 8'h11; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (rises[0] != 13 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL abort_reach_bit12: got timeout want rises=13"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ss1, sclk1, mosi1, busy1} !== 4'b1000) begin
            errors++; $display("FAIL abort_pins: got ss/sclk/mosi/busy=%b want 1000", {ss1, sclk1, mosi1, busy1});
        end
        saw_done = 1'b0;
        repeat (300) begin @(negedge clk); if (done1) saw_done = 1'b1; end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
        checks++;
        if (rdata1 !== 8'hA5) begin errors++; $display("FAIL abort_rdata: got %h want A5", rdata1); end
        checks++;
        if (mem[8'h30] !== 8'h00) begin errors++; $display("FAIL abort_no_write: got %h want 00", mem[8'h30]); end
        do_frame(0, 1'b1, 8'h20, 8'h5A, 1'b0, 0, 0, lat, g, s);
        @(negedge clk);
        checks++;
        if (lat !== 209 || mem[8'h20] !== 8'h5A) begin
            errors++; $display("FAIL abort_recover: got lat=%0d reg=%h want 209/5A", lat, mem[8'h20]);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, g1, g2; logic s1, s2;
        do_frame(0, 1'b1, 8'h21, 8'hC3, 1'b0, 0, 0, lat1, g1, s1);
        do_frame(0, 1'b1, 8'h22, 8'h96, 1'b1, 0, 0, lat2, g2, s2);
        @(negedge clk);
        checks++;
        if (g1 !== 8) begin errors++; $display("FAIL b2b_gap: got ss-high %0d cycles want 8", g1); end
        checks++;
        if (s2 !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got ss=%b want 0", s2); end
        checks++;
        if (lat1 !== 209 || lat2 !== 209) begin
            errors++; $display("FAIL b2b_latency: got %0d/%0d want 209/209", lat1, lat2);
        end
        checks++;
        if (mem[8'h21] !== 8'hC3 || mem[8'h22] !== 8'h96) begin
            errors++; $display("FAIL b2b_regs: got %h/%h want C3/96", mem[8'h21], mem[8'h22]);
        end
    endtask

    task automatic test_clk_div;
        int lat, g; logic s;
        do_frame(0, 1'b0, 8'h13, 8'h00, 1'b0, 0, 0, lat, g, s);
        checks++;
        if (rdata1 !== 8'h3C) begin errors++; $display("FAIL div4_rdata: got %h want 3C", rdata1); end
        checks++;
        if (last_high[0] !== 4) begin errors++; $display("FAIL div4_half_period: got %0d want 4", last_high[0]); end
        do_frame(1, 1'b0, 8'h13, 8'h00, 1'b0, 0, 0, lat, g, s);
        checks++;
        if (rdata2 !== 8'h3C) begin errors++; $display("FAIL div16_rdata: got %h want 3C", rdata2); end
        checks++;
        if (lat !== 797) begin errors++; $display("FAIL div16_latency: got %0d want 797", lat); end
        checks++;
        if (last_high[1] !== 16) begin errors++; $display("FAIL div16_half_period: got %0d want 16", last_high[1]); end
        checks++;
        if (last_rises[1] !== 24) begin errors++; $display("FAIL div16_rises: got %0d want 24", last_rises[1]); end
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; sr[i] = '0; last_frame[i] = '0; last_rises[i] = 0; cap_addr[i] = '0;
            prev_ss[i] = 1'b1; prev_sclk[i] = 1'b0; run[i] = 0; last_high[i] = 0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
        test_clk_div;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
